// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 8-bit shift/rotate engine.
// Accepts one request at a time through a start/ready handshake, shifts one
// bit position per clock, then presents result/carry/zero with a one-cycle
// done pulse. Operands are captured at acceptance, so the requester may
// change its inputs while the operation runs.

`ifndef SHL_FN
`define SHL_FN 2'b00
`endif
`ifndef SHR_FN
`define SHR_FN 2'b01
`endif
`ifndef ROL_FN
`define ROL_FN 2'b10
`endif
`ifndef ROR_FN
`define ROR_FN 2'b11
`endif

module shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [1:0] opcode,
  input  logic [2:0] count,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] work_q, work_d;
  logic       c_work_q, c_work_d;
  logic [2:0] rem_q, rem_d;
  logic [1:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       done_q, done_d;

  logic [7:0] step_work_s;
  logic       step_carry_s;

  // One single-position step. Returns {carry_out, shifted_value}.
  // Rotates never produce a carry; shifts report the bit pushed out.
  function automatic logic [8:0] shift_step(input logic [1:0] op,
                                            input logic [7:0] val);
    logic [8:0] res;
    case (op)
      `SHL_FN: res = {val[7], val[6:0], 1'b0};
      `SHR_FN: res = {val[0], 1'b0, val[7:1]};
      `ROL_FN: res = {1'b0, val[6:0], val[7]};
      `ROR_FN: res = {1'b0, val[0], val[7:1]};
      default: res = {1'b0, val};
    endcase
    return res;
  endfunction

  // Value and carry produced by the step taken this cycle.
  always_comb begin
    {step_carry_s, step_work_s} = shift_step(op_q, work_q);
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    c_work_d = c_work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is deliberately ignored here; start wins.
        if (start) begin
          work_d   = data_in;
          op_d     = opcode;
          rem_d    = count;
          c_work_d = 1'b0;
          if (count != 3'd0) begin
            state_d = SHIFT;
          end else begin
            // Zero-count request: publish the operand unchanged.
            state_d  = DONE;
            result_d = data_in;
            carry_d  = 1'b0;
            zero_d   = (data_in == 8'h00);
            done_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          // Cancel: published flags keep their previous values.
          state_d = IDLE;
        end else begin
          work_d   = step_work_s;
          c_work_d = step_carry_s;
          rem_d    = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d  = DONE;
            result_d = step_work_s;
            carry_d  = step_carry_s;
            zero_d   = (step_work_s == 8'h00);
            done_d   = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= 8'h00;
      c_work_q <= 1'b0;
      rem_q    <= 3'd0;
      op_q     <= 2'b00;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      c_work_q <= c_work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  // Handshake status decoded directly from the state register.
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q != IDLE);
  end

  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver issues requests and pushes
// the expected response; an independent monitor compares on every done.

`ifndef SHL_FN
`define SHL_FN 2'b00
`endif
`ifndef SHR_FN
`define SHR_FN 2'b01
`endif
`ifndef ROL_FN
`define ROL_FN 2'b10
`endif
`ifndef ROR_FN
`define ROR_FN 2'b11
`endif

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] opcode = 2'b00;
  logic [2:0] count = 3'd0;
  logic       abort = 1'b0;
  logic       ready, busy, done, carry, zero;
  logic [7:0] result;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .opcode(opcode), .count(count), .abort(abort), .ready(ready),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int c;
    int z;
    int stamp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hold_res = 0, hold_c = 0, hold_z = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operation result from plain arithmetic on the count.
  function automatic void model(input logic [1:0] op, input int d, input int n,
                                output int r, output int c);
    r = 0;
    c = 0;
    case (op)
      `SHL_FN: begin r = (d << n) & 255; c = (n != 0) ? ((d >> (8 - n)) & 1) : 0; end
      `SHR_FN: begin r = d >> n;         c = (n != 0) ? ((d >> (n - 1)) & 1) : 0; end
      `ROL_FN: begin r = ((d << n) | (d >> (8 - n))) & 255; c = 0; end
      default: begin r = ((d >> n) | (d << (8 - n))) & 255; c = 0; end
    endcase
  endfunction

  // Issue a request; abort_k>0 cancels it at the k-th edge after acceptance.
  // Returns at the negedge just after the acceptance edge (or after abort).
  task automatic issue(input logic [1:0] op, input int d, input int n, input int abort_k);
    int   guard;
    int   r, c;
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    data_in = d[7:0];
    opcode  = op;
    count   = n[2:0];
    guard   = 0;
    while (!ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", int'(ready), 1);
    if (!ready) begin
      start = 1'b0;
      return;
    end
    model(op, d, n, r, c);
    e.res   = r;
    e.c     = c;
    e.z     = (r == 0) ? 1 : 0;
    e.stamp = cyc + 1 + n;
    q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'($urandom);
    opcode  = 2'($urandom);
    count   = 3'($urandom);
    chk("ready_low_after_accept", int'(ready), 0);
    chk("busy_after_accept", int'(busy), 1);
    if (abort_k > 0) begin
      repeat (abort_k - 1) @(negedge clk);
      abort = 1'b1;
      void'(q.pop_back());
      @(negedge clk);
      abort = 1'b0;
      chk("ready_after_abort", int'(ready), 1);
      chk("abort_done_low", int'(done), 0);
      chk("abort_result_hold", int'(result), hold_res);
      chk("abort_carry_hold", int'(carry), hold_c);
      chk("abort_zero_hold", int'(zero), hold_z);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("carry", int'(carry), e.c);
        chk("zero", int'(zero), e.z);
        chk("done_cycle", cyc, e.stamp);
        hold_res = e.res;
        hold_c   = e.c;
        hold_z   = e.z;
      end
    end
  end

  initial begin
    int n_busy;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 0);
    rst_n = 1'b1;

    issue(`SHL_FN, 8'h81, 1, 0);
    issue(`SHL_FN, 8'h40, 2, 0);
    issue(`ROL_FN, 8'h81, 3, 0);
    issue(`ROR_FN, 8'h01, 7, 0);
    n_busy = 1;
    repeat (10) begin
      @(negedge clk);
      if (busy) n_busy++;
    end
    chk("ror7_busy_cycles", n_busy, 8);
    issue(`SHR_FN, 8'hA5, 0, 0);

    // Ignored start while busy, then abort in SHIFT.
    issue(`SHR_FN, 8'h80, 6, 0);
    @(negedge clk);
    start = 1'b1; data_in = 8'h3C; opcode = `ROL_FN; count = 3'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_hold_result", int'(result), hold_res);
    chk("abort_hold_carry", int'(carry), hold_c);
    chk("abort_hold_zero", int'(zero), hold_z);
    issue(`ROL_FN, 8'h3C, 2, 0);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 60; i++) begin
      int n, k;
      n = $urandom_range(7, 0);
      k = (n > 0 && $urandom_range(4, 0) == 0) ? $urandom_range(n, 1) : 0;
      issue(2'($urandom), $urandom_range(255, 0), n, k);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a shift.
    issue(`SHL_FN, 8'hFF, 5, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_carry", int'(carry), 0);
    chk("midrst_zero", int'(zero), 0);
    q.delete();
    hold_res = 0; hold_c = 0; hold_z = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(`SHL_FN, 8'h01, 7, 0);

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that sequences 8-bit shift/rotate operations one bit position per clock, with a start/ready/done handshake. It sits between the control unit and the register file/flags: the control unit issues a shift request, and on completion the registered result is written back together with carry and zero flags. Operand, opcode and count are captured once at acceptance. The requester is free to change its inputs while the operation runs.

## Interface
- No parameters. Width is fixed at 8 data bits and 3 count bits. Opcode encodings are the `SHL_FN`, `SHR_FN`, `ROL_FN` and `ROR_FN` macros from `defines.sv`.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request valid; level-sensitive; accepted only when `ready` is 1
- data_in  in  8  operand, sampled at acceptance
- opcode  in  2  shift function, sampled at acceptance
- count  in  3  number of positions (0–7), sampled at acceptance
- abort  in  1  synchronous cancel of an operation in progress
- ready  out  1  1 in IDLE only (combinational from state)
- busy  out  1  1 in SHIFT or DONE
- done  out  1  one-cycle pulse; result outputs valid from that cycle
- result  out  8  registered shifted value
- carry  out  1  registered carry flag
- zero  out  1  registered flag, 1 when the final value is 8'h00

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: work[7:0], c_work, rem[2:0], op[1:0].
- IDLE with start=1 (accept):
  - work←data_in, op←opcode, rem←count, c_work←0.
  - Next state is SHIFT if count≠0, otherwise DONE.
- SHIFT, one step per cycle:
  - SHL: c_work←work[7], work←{work[6:0],0}.
  - SHR: c_work←work[0], work←{0,work[7:1]}.
  - ROL: work←{work[6:0],work[7]}, c_work stays 0.
  - ROR: work←{work[0],work[7:1]}, c_work stays 0.
  - rem←rem−1. When the step is taken with rem=1, next state is DONE.
- Entry to DONE (same edge that sets the state): result←work after the final step, carry←c_work, zero←(final work==0).
- DONE lasts exactly one cycle: done=1, then IDLE.
- result, carry and zero hold until the next DONE entry. They are never modified by abort.
- count=0: result=data_in, carry=0, zero per data_in.
- Carry semantics: SHL/SHR give the last bit shifted out; ROL/ROR always give 0.
- start while busy is ignored and not queued. The requester keeps start high until it sees ready=1.
- abort=1 in SHIFT: next state IDLE, no done pulse, result/carry/zero unchanged.
- abort in IDLE or DONE: no effect. DONE still completes and pulses done.
- abort and start both high in IDLE: abort ignored, request accepted.

## Timing
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - work, rem, op, c_work, result, carry, zero all 0.
  - done=0, busy=0, ready=1.
- Latency: with acceptance at edge E, done is high during the cycle after edge E+count, i.e. count+1 cycles after acceptance. count=0 gives done in the cycle after edge E.
- Throughput: the next acceptance can occur at the edge ending DONE+1, i.e. the first edge where ready=1 again. Minimum spacing between acceptances is count+2 cycles.
- rst_n asserted mid-operation: immediate return to the reset state with no done pulse. The first acceptance is possible at the first rising edge after rst_n deasserts.
- rem counts down to exactly 0. There is no wrap-around. At most 7 steps.

## Test plan
- SHL, data 8'h81, count 1:
  - ready drops the cycle after acceptance; done 2 cycles after acceptance.
  - result 8'h02, carry 1, zero 0.
- SHL, data 8'h40, count 2: result 8'h00, carry 1, zero 1, done 3 cycles after acceptance.
- ROL, data 8'h81, count 3: result 8'h0C, carry 0. Then ROR, data 8'h01, count 7: result 8'h02, carry 0; busy high for 8 cycles.
- SHR, data 8'hA5, count 0: done the cycle after acceptance; result 8'hA5, carry 0, zero 0.
- Overlapping start and abort:
  - Accept SHR, data 8'h80, count 6. Pulse start with different operands on cycle 2; it is ignored.
  - abort on cycle 3: return to IDLE, no done, result/carry/zero keep their previous values.
  - A new request is then accepted normally.
- Reset mid-operation: drop rst_n during SHIFT of SHL 8'hFF count 5. All outputs read 0 and ready reads 1 immediately. After release, SHL 8'h01 count 7 gives 8'h80, carry 0.
